// File: rtl/vga_scanout.sv
// 640x480@60 scan-out of a 160x120 RGB444 framebuffer with 4x4 pixel replication.
// The framebuffer base is double-buffered and swaps at the frame wrap, so page flips never tear.
`timescale 1ns/1ps
module vga_scanout #(
    parameter int READ_LATENCY = 1,
    parameter int FB_WIDTH     = 160
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] base,
    output logic [15:0] address,
    input  logic [15:0] q,
    output logic [3:0]  VGA_R,
    output logic [3:0]  VGA_G,
    output logic [3:0]  VGA_B,
    output logic        HS,
    output logic        VS,
    output logic        frame_start
);

    localparam logic [9:0]  H_VIS     = 10'd640;
    localparam logic [9:0]  H_SYNC_S  = 10'd656;
    localparam logic [9:0]  H_SYNC_E  = 10'd751;
    localparam logic [9:0]  H_LAST    = 10'd799;
    localparam logic [9:0]  V_VIS     = 10'd480;
    localparam logic [9:0]  V_SYNC_S  = 10'd490;
    localparam logic [9:0]  V_SYNC_E  = 10'd491;
    localparam logic [9:0]  V_LAST    = 10'd524;
    localparam logic [15:0] ROW_STEP  = 16'(FB_WIDTH);

    logic [9:0]  h_count;
    logic [9:0]  v_count;
    logic [15:0] row_base;
    logic [15:0] base_reg;
    logic        h_last;
    logic        v_last;
    logic        visible;
    logic        hsync;
    logic        vsync;

    logic        vis_1;
    logic        hs_1;
    logic        vs_1;
    logic [READ_LATENCY-1:0] vis_pipe;
    logic [READ_LATENCY-1:0] hs_pipe;
    logic [READ_LATENCY-1:0] vs_pipe;
    logic [11:0] colour;
    logic        unused_q;

    assign unused_q = ^q[15:12];

    always_comb begin
        h_last  = (h_count == H_LAST);
        v_last  = (v_count == V_LAST);
        visible = (h_count < H_VIS) && (v_count < V_VIS);
        hsync   = (h_count >= H_SYNC_S) && (h_count <= H_SYNC_E);
        vsync   = (v_count >= V_SYNC_S) && (v_count <= V_SYNC_E);
    end

    // Stage 0: raster counters, incremental row base and the frame-latched page base.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            h_count     <= '0;
            v_count     <= '0;
            row_base    <= '0;
            base_reg    <= '0;
            frame_start <= 1'b0;
        end else begin
            if (h_last) begin
                h_count <= '0;
                v_count <= v_last ? 10'd0 : v_count + 10'd1;
            end else begin
                h_count <= h_count + 10'd1;
            end
            if (h_last && v_last) begin
                row_base <= '0;
                base_reg <= base;
            end else if (h_last && (v_count[1:0] == 2'd3) && (v_count < V_VIS)) begin
                row_base <= row_base + ROW_STEP;
            end
            frame_start <= (h_count == 10'd0) && (v_count == 10'd0);
        end
    end

    // Stage 1: read address (held through blanking) plus the raster flags.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            address <= '0;
            vis_1   <= 1'b0;
            hs_1    <= 1'b0;
            vs_1    <= 1'b0;
        end else begin
            if (visible) begin
                address <= base_reg + row_base + {8'h00, h_count[9:2]};
            end
            vis_1 <= visible;
            hs_1  <= hsync;
            vs_1  <= vsync;
        end
    end

    // Flags ride alongside the RAM read so sync and colour stay aligned to the raster.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vis_pipe <= '0;
            hs_pipe  <= '0;
            vs_pipe  <= '0;
        end else begin
            vis_pipe[0] <= vis_1;
            hs_pipe[0]  <= hs_1;
            vs_pipe[0]  <= vs_1;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vis_pipe[i] <= vis_pipe[i-1];
                hs_pipe[i]  <= hs_pipe[i-1];
                vs_pipe[i]  <= vs_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            colour <= '0;
            HS     <= 1'b1;
            VS     <= 1'b1;
        end else begin
            colour <= vis_pipe[READ_LATENCY-1] ? q[11:0] : 12'h000;
            HS     <= ~hs_pipe[READ_LATENCY-1];
            VS     <= ~vs_pipe[READ_LATENCY-1];
        end
    end

    assign VGA_R = colour[11:8];
    assign VGA_G = colour[7:4];
    assign VGA_B = colour[3:0];

endmodule
